apb_fir_engine: RTL and testbench
=================================

Name: apb_fir_engine

Overview:
- APB-slave FIR accelerator with run-time programmable coefficients.
- Time-multiplexed single multiply-accumulate datapath (NTAPS cycles per sample).
- Output result FIFO, sticky error flags and a level interrupt.
- Sits on the peripheral APB bus as a 4KB slave. Software writes samples, then polls STATUS or waits for irq before reading results.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width.
- NTAPS, 8, number of taps (2..32).
- IW, 12, signed sample width.
- TW, 12, signed coefficient width.
- OW, IW+TW+$clog2(NTAPS), accumulator/result width; must be <=32.
- OUT_DEPTH, 4, result FIFO depth (power of 2, >=2).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- PADDR  in  APB_ADDR_WIDTH  byte address; word offset = PADDR[11:2].
- PWDATA  in  32  write data.
- PWRITE  in  1  write strobe.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PRDATA  out  32  read data (combinational).
- PREADY  out  1  constant 1.
- PSLVERR  out  1  1 during access phase to an unmapped offset.
- irq  out  1  CTRL.irq_en & !fifo_empty, registered.

Behaviour:
- Access = PSEL&PENABLE. Writes and pops take effect on the HCLK edge ending the access.
- Register map (byte offsets):
  - 0x00 CTRL: b0 enable, b1 clear (self-clearing, reads 0), b2 irq_en.
  - 0x04 SAMPLE (WO): pushes PWDATA[IW-1:0] as a signed sample.
  - 0x08 RESULT (RO, pop): returns FIFO head sign-extended OW->32, then pops. When empty it returns 0 and sets underflow.
  - 0x0C STATUS: b0 busy, b1 empty, b2 full, b3 overflow (sticky), b4 underflow (sticky). W1C on b3/b4; other bits RO.
  - 0x10 COUNT: 32-bit count of accepted samples, wraps.
  - 0x14 LEVEL: FIFO occupancy 0..OUT_DEPTH.
  - 0x40+4k TAP[k], k<NTAPS: RW, signed TW bits, read sign-extended.
  - All other offsets: PRDATA=0, PSLVERR=1, writes ignored.
- Reset (async, HRESETn=0): CTRL=0, taps=0, history=0, acc=0, FIFO empty, stickies=0, COUNT=0, FSM=IDLE, irq=0.
- Sample acceptance: enable & FSM==IDLE & !full.
  - Accepted: hist shifts (hist[0]=new sample, hist[k]=old hist[k-1]), acc<=0, idx<=0, COUNT++, FSM->MAC.
  - Rejected: sample dropped, overflow<=1, COUNT unchanged, history unchanged.
- FSM:
  - IDLE: wait for an accepted sample.
  - MAC: each cycle acc += sext(TAP[idx]*hist[idx]), a full-precision signed product; idx++. After idx==NTAPS-1 -> STORE.
  - STORE: push acc into FIFO -> IDLE.
  - busy = FSM!=IDLE.
- Latency: sample write at edge t; result visible in FIFO (LEVEL increments, empty drops) after edge t+NTAPS+1. Next sample accepted from edge t+NTAPS+2.
- Overflow arithmetic: none possible given OW. No saturation.
- FIFO: a push can never hit a full FIFO, because acceptance requires !full and only one sample is ever in flight. A pop and a push in the same cycle leave LEVEL unchanged.
- TAP write while busy: ignored, overflow<=1. TAP reads are always allowed.
- CTRL.clear=1:
  - Aborts MAC -> IDLE. In-flight result discarded.
  - History=0, FIFO emptied, stickies=0, COUNT=0.
  - Taps, enable and irq_en take the written values.
- enable=0 mid-MAC: current computation completes; new samples are rejected (overflow set).
- W1C of a sticky in the same cycle as its set event: set wins.
- irq updates one cycle after empty/irq_en change.

Test Plan:
1. Impulse: TAP[k]=k+1, enable=1; write 1 then seven 0s, draining RESULT after each -> reads 1,2,3,4,5,6,7,8; COUNT=8; PSLVERR=0.
2. Sign: all taps=1; write 0xFFD (-3) eight times with draining -> results 0xFFFFFFFD, 0xFFFFFFFA, ..., 0xFFFFFFE8 (-24).
3. Busy drop: two back-to-back SAMPLE writes -> second dropped; STATUS.b3=1; COUNT=1; LEVEL=1 after NTAPS+2 cycles. W1C 0x8 -> b3=0.
4. FIFO full/irq: irq_en=1, five paced samples without reads -> LEVEL=4, full=1, 5th dropped, overflow=1, irq=1. Four reads -> irq=0; 5th read returns 0 and sets underflow=1.
5. Clear mid-MAC: write sample, then CTRL=0x3 two cycles later -> busy=0, LEVEL=0, COUNT=0, no result appears; taps unchanged.
6. Async reset mid-MAC: HRESETn low between edges -> immediately busy=0, irq=0, all taps read 0; access to 0x30 gives PSLVERR=1.

Source files
------------

// File: rtl/apb_fir_engine.sv
// apb_fir_engine: APB slave FIR accelerator with programmable taps, one shared MAC and a result FIFO.
module apb_fir_engine #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NTAPS = 8,
  parameter int IW = 12,
  parameter int TW = 12,
  parameter int OW = IW + TW + $clog2(NTAPS),
  parameter int OUT_DEPTH = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      irq
);
  localparam int TIW = $clog2(NTAPS);
  localparam int AW = $clog2(OUT_DEPTH);
  typedef enum logic [1:0] {IDLE, MAC, STORE} state_t;
  state_t state, state_nx;
  logic en, irq_en, ovf, udf;
  logic [31:0] count;
  logic signed [TW-1:0] taps [NTAPS];
  logic signed [IW-1:0] hist [NTAPS];
  logic signed [OW-1:0] acc;
  logic signed [OW-1:0] mem [OUT_DEPTH];
  logic signed [IW+TW-1:0] prod;
  logic [TIW-1:0] idx;
  logic [AW:0] wp, rp, level;
  logic [9:0] off, toff;
  logic access, wr, rd, is_tap, mapped, empty, full, busy;
  logic clr, accept, ovf_set, udf_set, push, pop, unused_ok;
  assign off = PADDR[11:2];
  assign toff = off - 10'd16;
  assign is_tap = off >= 10'd16 && off < 10'(16 + NTAPS);
  assign mapped = off <= 10'd5 || is_tap;
  assign access = PSEL & PENABLE;
  assign wr = access & PWRITE & mapped;
  assign rd = access & ~PWRITE;
  assign level = wp - rp;
  assign empty = level == '0;
  assign full = level == (AW+1)'(OUT_DEPTH);
  assign busy = state != IDLE;
  assign clr = wr && off == 10'd0 && PWDATA[1];
  assign accept = wr && off == 10'd1 && en && !busy && !full;
  assign ovf_set = (wr && off == 10'd1 && !accept) || (wr && is_tap && busy);
  assign udf_set = rd && off == 10'd2 && empty;
  assign pop = rd && off == 10'd2 && !empty;
  assign push = state == STORE && !clr;
  assign prod = (IW+TW)'(taps[idx]) * (IW+TW)'(hist[idx]);
  assign PREADY = 1'b1;
  assign PSLVERR = access & ~mapped;
  assign unused_ok = ^{PWDATA, PADDR, toff};
  always_comb
    state_nx = clr ? IDLE : accept ? MAC : (state == MAC && idx == TIW'(NTAPS - 1)) ? STORE :
               state == STORE ? IDLE : state;
  always_comb begin
    PRDATA = '0;
    if (is_tap) PRDATA = 32'(taps[toff[TIW-1:0]]);
    else case (off)
      10'd0: PRDATA = {29'd0, irq_en, 1'b0, en};
      10'd2: PRDATA = empty ? '0 : 32'(mem[rp[AW-1:0]]);
      10'd3: PRDATA = {27'd0, udf, ovf, full, empty, busy};
      10'd4: PRDATA = count;
      10'd5: PRDATA = 32'(level);
      default: ;
    endcase
  end
  always_ff @(posedge HCLK)
    if (push) mem[wp[AW-1:0]] <= acc;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      en <= 1'b0;
      irq_en <= 1'b0;
      ovf <= 1'b0;
      udf <= 1'b0;
      count <= '0;
      acc <= '0;
      idx <= '0;
      wp <= '0;
      rp <= '0;
      irq <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        taps[i] <= '0;
        hist[i] <= '0;
      end
    end else begin
      state <= state_nx;
      irq <= irq_en & ~empty;
      if (wr && off == 10'd0) begin
        en <= PWDATA[0];
        irq_en <= PWDATA[2];
      end
      if (wr && is_tap && !busy) taps[toff[TIW-1:0]] <= PWDATA[TW-1:0];
      if (clr) begin
        for (int i = 0; i < NTAPS; i++) hist[i] <= '0;
        wp <= '0;
        rp <= '0;
        ovf <= 1'b0;
        udf <= 1'b0;
        count <= '0;
      end else begin
        // sticky set beats a same-cycle W1C
        ovf <= (ovf & ~(wr && off == 10'd3 && PWDATA[3])) | ovf_set;
        udf <= (udf & ~(wr && off == 10'd3 && PWDATA[4])) | udf_set;
        if (accept) begin
          for (int i = NTAPS - 1; i > 0; i--) hist[i] <= hist[i-1];
          hist[0] <= PWDATA[IW-1:0];
          acc <= '0;
          idx <= '0;
          count <= count + 32'd1;
        end else if (state == MAC) begin
          acc <= acc + OW'(prod);
          idx <= idx + 1'b1;
        end
        if (state == STORE) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
      end
    end
endmodule

// File: tb/tb_apb_fir_engine.sv
// tb_apb_fir_engine: scoreboard bench for apb_fir_engine; expected results queued at sample write.
module tb_apb_fir_engine;
  localparam int NTAPS = 8, IW = 12, TW = 12;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0, PRDATA;
  logic PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PREADY, PSLVERR, irq;
  int checks = 0, failures = 0;
  int mtaps [NTAPS];
  int mhist [NTAPS];
  logic [31:0] q [$];
  logic [31:0] rd;
  logic err;

  apb_fir_engine #(.NTAPS(NTAPS), .IW(IW), .TW(TW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic apb_write(logic [11:0] a, logic [31:0] d);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge HCLK); #1 PENABLE = 1'b1;
    @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(logic [11:0] a, output logic [31:0] d, output logic e);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge HCLK); #1 PENABLE = 1'b1;
    #3 d = PRDATA; e = PSLVERR;
    @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic set_tap(int k, int v);
    apb_write(12'(32'h40 + 4 * k), 32'(v));
    mtaps[k] = int'($signed(v[TW-1:0]));
  endtask

  task automatic model_clear();
    for (int k = 0; k < NTAPS; k++) mhist[k] = 0;
    q.delete();
  endtask

  task automatic send(logic [31:0] d, bit ok);
    int s;
    apb_write(12'h004, d);
    if (ok) begin
      for (int k = NTAPS - 1; k > 0; k--) mhist[k] = mhist[k-1];
      mhist[0] = int'($signed(d[IW-1:0]));
      s = 0;
      for (int k = 0; k < NTAPS; k++) s += mtaps[k] * mhist[k];
      q.push_back(32'(s));
    end
  endtask

  task automatic pop_check(string tag);
    logic [31:0] e;
    e = 32'd0;
    if (q.size() > 0) e = q.pop_front();
    apb_read(12'h008, rd, err);
    check(tag, rd, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NTAPS; k++) begin mtaps[k] = 0; mhist[k] = 0; end
    cycles(3);
    HRESETn = 1'b1;
    cycles(1);
    apb_read(12'h000, rd, err); check("rst_ctrl", rd, 0);
    apb_read(12'h00C, rd, err); check("rst_status", rd, 32'h2);
    apb_read(12'h010, rd, err); check("rst_count", rd, 0);
    apb_read(12'h014, rd, err); check("rst_level", rd, 0);
    apb_read(12'h04C, rd, err); check("rst_tap3", rd, 0);
    check("rst_irq", irq, 0);
    check("pready", PREADY, 1);
    // impulse response with latency boundary on the first sample
    for (int k = 0; k < NTAPS; k++) set_tap(k, k + 1);
    apb_write(12'h000, 32'h1);
    send(32'h1, 1'b1);
    cycles(NTAPS - 1);
    apb_read(12'h00C, rd, err); check("lat_status", rd, 32'h3);
    apb_read(12'h014, rd, err); check("lat_level", rd, 1);
    pop_check("imp0");
    check("imp_slverr", err, 0);
    for (int i = 1; i < NTAPS; i++) begin
      send(32'h0, 1'b1);
      cycles(NTAPS + 2);
      pop_check("imp");
    end
    apb_read(12'h010, rd, err); check("imp_count", rd, 8);
    // negative samples
    for (int k = 0; k < NTAPS; k++) set_tap(k, 1);
    apb_write(12'h000, 32'h3); model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      send(32'hFFD, 1'b1);
      cycles(NTAPS + 2);
      pop_check("sign");
    end
    check("sign_last", rd, 32'hFFFFFFE8);
    // busy drop and acceptance boundary
    apb_write(12'h000, 32'h3); model_clear();
    send(32'd5, 1'b1);
    send(32'd7, 1'b0);
    apb_read(12'h00C, rd, err); check("drop_ovf", rd[3], 1);
    apb_read(12'h010, rd, err); check("drop_count", rd, 1);
    cycles(NTAPS - 6);
    send(32'd9, 1'b1);
    cycles(NTAPS + 2);
    apb_read(12'h014, rd, err); check("drop_level", rd, 2);
    apb_read(12'h010, rd, err); check("drop_count2", rd, 2);
    apb_write(12'h00C, 32'h8);
    apb_read(12'h00C, rd, err); check("w1c_ovf", rd[3], 0);
    pop_check("drop_r0");
    pop_check("drop_r1");
    // fifo full, irq, underflow
    apb_write(12'h000, 32'h5);
    for (int i = 0; i < 4; i++) begin
      send(32'(i * 3 + 1), 1'b1);
      cycles(NTAPS + 2);
    end
    apb_read(12'h014, rd, err); check("full_level", rd, 4);
    apb_read(12'h00C, rd, err); check("full_flag", rd[2], 1);
    check("full_irq", irq, 1);
    send(32'd100, 1'b0);
    apb_read(12'h00C, rd, err); check("full_ovf", rd[3], 1);
    apb_read(12'h010, rd, err); check("full_count", rd, 6);
    for (int i = 0; i < 4; i++) pop_check("fifo");
    cycles(1);
    check("drain_irq", irq, 0);
    pop_check("under");
    apb_read(12'h00C, rd, err); check("under_flag", rd[4], 1);
    // clear mid-MAC
    apb_write(12'h000, 32'h3); model_clear();
    send(32'd21, 1'b0);
    apb_write(12'h000, 32'h3); model_clear();
    apb_read(12'h00C, rd, err); check("clr_status", rd, 32'h2);
    apb_read(12'h010, rd, err); check("clr_count", rd, 0);
    cycles(NTAPS + 2);
    apb_read(12'h014, rd, err); check("clr_level", rd, 0);
    apb_read(12'h048, rd, err); check("clr_tap2", rd, 32'(mtaps[2]));
    // tap write while busy is ignored
    send(32'd4, 1'b1);
    apb_write(12'h040, 32'h55);
    apb_read(12'h00C, rd, err); check("tapbusy_status", rd, 32'hB);
    apb_read(12'h040, rd, err); check("tapbusy_tap0", rd, 32'(mtaps[0]));
    cycles(NTAPS + 2);
    pop_check("tapbusy_res");
    // async reset mid-MAC
    apb_write(12'h000, 32'h5);
    send(32'd6, 1'b1);
    cycles(NTAPS + 2);
    check("pre_rst_irq", irq, 1);
    send(32'd7, 1'b1);
    cycles(2);
    #3 HRESETn = 1'b0;
    #1 check("arst_irq", irq, 0);
    PADDR = 12'h00C;
    #1 check("arst_status", PRDATA, 32'h2);
    model_clear();
    for (int k = 0; k < NTAPS; k++) mtaps[k] = 0;
    cycles(2);
    HRESETn = 1'b1;
    cycles(1);
    for (int k = 0; k < NTAPS; k++) begin
      apb_read(12'(32'h40 + 4 * k), rd, err);
      check("arst_tap", rd, 32'(mtaps[k]));
    end
    apb_read(12'h030, rd, err);
    check("unmapped_err", err, 1);
    check("unmapped_data", rd, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
